// File: rtl/fetch_decode_ctrl_if.sv
// Bundle of the fetch, decode, issue and redirect signals around fetch_decode_ctrl.
// The master modport is the controller's view; slave is memory/decoder/execute.
interface fetch_decode_ctrl_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] ir;
  logic            dec_valid;
  logic            issue_valid;
  logic            issue_ready;
  logic [XLEN-1:0] issue_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap;
  logic [1:0]      trap_cause;
  logic [XLEN-1:0] instret;

  modport master (
    output imem_req, imem_addr, ir, issue_valid, issue_pc, trap, trap_cause, instret,
    input  imem_gnt, imem_rvalid, imem_rdata, dec_valid, issue_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, ir, issue_valid, issue_pc, trap, trap_cause, instret,
    output imem_gnt, imem_rvalid, imem_rdata, dec_valid, issue_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode sequencer: fetches one instruction at a time, holds it in ir for the
// decoder, issues it to execute, owns the PC and traps on illegal opcodes or bad redirects.
module fetch_decode_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  fetch_decode_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_ISSUE,
    S_TRAP
  } state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_MISALGN = 2'b10;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] issue_pc_q, issue_pc_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic [1:0]      trap_cause_q, trap_cause_d;

  logic redir_ok;
  logic redir_bad;

  assign redir_ok  = bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
  assign redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      ir_q         <= '0;
      issue_pc_q   <= '0;
      instret_q    <= '0;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      ir_q         <= ir_d;
      issue_pc_q   <= issue_pc_d;
      instret_q    <= instret_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  // A misaligned redirect wins over everything else in every non-trap state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    ir_d         = ir_q;
    issue_pc_d   = issue_pc_q;
    instret_d    = instret_q;
    trap_cause_d = trap_cause_q;

    if (state_q != S_TRAP && redir_bad) begin
      state_d      = S_TRAP;
      trap_cause_d = CAUSE_MISALGN;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.imem_gnt) begin
            state_d = S_WAIT;
          end
          if (redir_ok) begin
            pc_d = bus.redirect_pc;
            if (bus.imem_gnt) begin
              drop_d = 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (redir_ok) begin
            pc_d = bus.redirect_pc;
            if (bus.imem_rvalid) begin
              drop_d  = 1'b0;
              state_d = S_FETCH;
            end else begin
              drop_d = 1'b1;
            end
          end else if (bus.imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_FETCH;
            end else begin
              ir_d       = bus.imem_rdata;
              issue_pc_d = pc_q;
              state_d    = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          if (redir_ok) begin
            pc_d    = bus.redirect_pc;
            state_d = S_FETCH;
          end else if (bus.dec_valid) begin
            state_d = S_ISSUE;
          end else begin
            state_d      = S_TRAP;
            trap_cause_d = CAUSE_ILLEGAL;
          end
        end
        S_ISSUE: begin
          if (bus.issue_ready) begin
            instret_d = instret_q + 1'b1;
            pc_d      = redir_ok ? bus.redirect_pc : pc_q + XLEN'(4);
            state_d   = S_FETCH;
          end else if (redir_ok) begin
            pc_d    = bus.redirect_pc;
            state_d = S_FETCH;
          end
        end
        default: begin
          state_d = S_TRAP;
        end
      endcase
    end
  end

  always_comb begin
    bus.imem_req    = 1'b0;
    bus.issue_valid = 1'b0;
    bus.trap        = 1'b0;
    case (state_q)
      S_FETCH: bus.imem_req    = 1'b1;
      S_ISSUE: bus.issue_valid = 1'b1;
      S_TRAP:  bus.trap        = 1'b1;
      default: ;
    endcase
  end

  assign bus.imem_addr  = pc_q;
  assign bus.ir         = ir_q;
  assign bus.issue_pc   = issue_pc_q;
  assign bus.instret    = instret_q;
  assign bus.trap_cause = trap_cause_q;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed scenarios plus a randomized run scored against an architectural PC model:
// every issued instruction must be the memory word at the PC implied by issues and redirects.
module tb_fetch_decode_ctrl;

  logic clk;
  logic rst;

  fetch_decode_ctrl_if #(.XLEN(32)) bus ();

  fetch_decode_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // The decoder stand-in flags only the all-ones word as illegal.
  assign bus.dec_valid = (bus.ir != 32'hFFFF_FFFF);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          errors   = 0;
  int          checks   = 0;
  int          n_issued = 0;
  bit          rand_on  = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_ir;
  logic [31:0] prev_pc;
  logic [31:0] model_pc;
  logic [31:0] addr_l;
  bit          pend;
  int          lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a * 32'h9E37_79B1) & 32'hFFFF_FFFB) | 32'h0000_0003;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                               input logic ready, input logic rv, input logic [31:0] rpc);
    bus.imem_gnt       = gnt;
    bus.imem_rvalid    = rvalid;
    bus.imem_rdata     = rdata;
    bus.issue_ready    = ready;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    step();
  endtask

  task automatic idleInputs();
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.issue_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: pops the expected instruction on every issue handshake.
  always @(negedge clk) begin
    if (rand_on) begin
      if (prev_stall) begin
        checkOutput("stall_valid", {31'd0, bus.issue_valid}, 32'd1);
        checkOutput("stall_ir", bus.ir, prev_ir);
        checkOutput("stall_pc", bus.issue_pc, prev_pc);
      end
      if (bus.issue_valid && bus.issue_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_issue: got pc 0x%08h expected no issue", bus.issue_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("issue_pc", bus.issue_pc, e.pc);
          checkOutput("issue_ir", bus.ir, e.instr);
        end
        checkOutput("instret", bus.instret, 32'(n_issued));
        n_issued++;
      end
      prev_stall = bus.issue_valid && !bus.issue_ready && !bus.redirect_valid;
      prev_ir    = bus.ir;
      prev_pc    = bus.issue_pc;
    end
  end

  initial begin
    logic [31:0] tgt;
    rst = 1'b1;
    idleInputs();
    #2;
    step();
    rst = 1'b0;

    checkOutput("rst_req", {31'd0, bus.imem_req}, 32'd1);
    checkOutput("rst_addr", bus.imem_addr, 32'h0);
    checkOutput("rst_valid", {31'd0, bus.issue_valid}, 32'd0);
    checkOutput("rst_trap", {30'd0, bus.trap_cause}, 32'd0);
    checkOutput("rst_instret", bus.instret, 32'd0);
    checkOutput("rst_ir", bus.ir, 32'd0);

    // Back-to-back minimum-latency fetch and issue.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("wait_req", {31'd0, bus.imem_req}, 32'd0);
    applyStimulus(0, 1, 32'h0050_0093, 0, 0, 0);
    checkOutput("t1_ir", bus.ir, 32'h0050_0093);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t1_valid", {31'd0, bus.issue_valid}, 32'd1);
    checkOutput("t1_issue_pc", bus.issue_pc, 32'h0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("t1_next_addr", bus.imem_addr, 32'h4);
    checkOutput("t1_instret", bus.instret, 32'd1);
    checkOutput("t1_valid_drop", {31'd0, bus.issue_valid}, 32'd0);

    // Execute stalls for three cycles.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h00A0_0113, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("t2_valid", {31'd0, bus.issue_valid}, 32'd1);
      checkOutput("t2_ir", bus.ir, 32'h00A0_0113);
      checkOutput("t2_issue_pc", bus.issue_pc, 32'h4);
      checkOutput("t2_pc", bus.imem_addr, 32'h4);
      checkOutput("t2_instret", bus.instret, 32'd1);
    end
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("t2_instret_rel", bus.instret, 32'd2);
    checkOutput("t2_next_addr", bus.imem_addr, 32'h8);

    // Redirect while the fetch is in flight drops the response.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h100);
    checkOutput("t3_still_wait", {31'd0, bus.imem_req}, 32'd0);
    applyStimulus(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    checkOutput("t3_req", {31'd0, bus.imem_req}, 32'd1);
    checkOutput("t3_addr", bus.imem_addr, 32'h100);
    checkOutput("t3_ir_kept", bus.ir, 32'h00A0_0113);
    checkOutput("t3_no_issue", {31'd0, bus.issue_valid}, 32'd0);

    // Misaligned redirect during a stalled issue.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h0000_0013, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t5_issue_pc", bus.issue_pc, 32'h100);
    applyStimulus(0, 0, 0, 0, 1, 32'h102);
    checkOutput("t5_trap", {31'd0, bus.trap}, 32'd1);
    checkOutput("t5_cause", {30'd0, bus.trap_cause}, 32'd2);
    checkOutput("t5_valid", {31'd0, bus.issue_valid}, 32'd0);
    checkOutput("t5_instret", bus.instret, 32'd2);

    // Asynchronous reset out of TRAP, between edges.
    idleInputs();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_req", {31'd0, bus.imem_req}, 32'd1);
    checkOutput("arst_trap", {31'd0, bus.trap}, 32'd0);
    checkOutput("arst_instret", bus.instret, 32'd0);
    step();
    rst = 1'b0;

    // Illegal opcode traps after DECODE and stays halted.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t4_trap", {31'd0, bus.trap}, 32'd1);
    checkOutput("t4_cause", {30'd0, bus.trap_cause}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'b0, 0);
      checkOutput("t4_req_low", {31'd0, bus.imem_req}, 32'd0);
      checkOutput("t4_trap_hold", {30'd0, bus.trap_cause}, 32'd1);
    end
    doReset();
    checkOutput("t4_rst_addr", bus.imem_addr, 32'h0);

    // Reset in the middle of WAIT; a late rvalid must be ignored.
    applyStimulus(1, 0, 0, 0, 0, 0);
    idleInputs();
    #3;
    rst = 1'b1;
    #1;
    checkOutput("t6_req", {31'd0, bus.imem_req}, 32'd1);
    checkOutput("t6_addr", bus.imem_addr, 32'h0);
    step();
    rst = 1'b0;
    applyStimulus(0, 1, 32'h1111_1111, 0, 0, 0);
    checkOutput("t6_still_fetch", {31'd0, bus.imem_req}, 32'd1);
    checkOutput("t6_ir", bus.ir, 32'h0);

    // Randomized traffic against the architectural PC model.
    doReset();
    model_pc = 32'h0;
    pend     = 1'b0;
    lat      = 0;
    rand_on  = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      idleInputs();
      if (pend) begin
        if (lat == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(addr_l);
          pend            = 1'b0;
        end else begin
          lat--;
        end
      end else if (bus.imem_req && $urandom_range(0, 3) != 0) begin
        bus.imem_gnt = 1'b1;
        addr_l       = bus.imem_addr;
        pend         = 1'b1;
        lat          = $urandom_range(0, 2);
      end
      bus.issue_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 99) < 8) begin
        case ($urandom_range(0, 5))
          0:       tgt = 32'hFFFF_FFF8;
          1:       tgt = 32'hFFFF_FFFC;
          default: tgt = $urandom & 32'h0000_0FFC;
        endcase
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = tgt;
      end
      if (bus.issue_valid && bus.issue_ready) begin
        exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
        model_pc = model_pc + 32'd4;
      end
      if (bus.redirect_valid) begin
        model_pc = bus.redirect_pc;
      end
      step();
    end
    rand_on = 1'b0;
    idleInputs();
    checkOutput("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("rand_enough_issues", {31'd0, n_issued > 20}, 32'd1);
    checkOutput("rand_instret_final", bus.instret, 32'(n_issued));
    checkOutput("rand_no_trap", {31'd0, bus.trap}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
